// File: rtl/logic_operand_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module      : logic_operand_queue_pkg
// Description : Shared op encoding and default sizing for the logic operand
//               queue and its bitwise unit.
// Revision    : 1.0 - initial release
// ============================================================================
package logic_operand_queue_pkg;

  // Bitwise operation selector carried with every queued operand pair
  typedef enum logic [1:0] {
    OP_AND  = 2'b00,
    OP_OR   = 2'b01,
    OP_XOR  = 2'b10,
    OP_ANDN = 2'b11
  } op_e;

  localparam int c_default_w     = 32;
  localparam int c_default_depth = 4;

  // Occupancy counter width: must represent 0..depth inclusive
  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/logic_operand_queue_logic32b_comb.sv
`default_nettype none
// ============================================================================
// Module      : logic32b_comb
// Description : Combinational W-bit bitwise unit (AND, OR, XOR, ANDN).
//               Pure per-bit logic, no carries, result width equals W.
// Revision    : 1.0 - initial release
// ============================================================================
module logic32b_comb
  import logic_operand_queue_pkg::*;
#(
  parameter int W = c_default_w
) (
  input  op_e          i_op,
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_c
);

  // Select one of the four bitwise functions of the operand pair
  always_comb begin
    o_c = '0;
    case (i_op)
      OP_AND:  o_c = i_a & i_b;
      OP_OR:   o_c = i_a | i_b;
      OP_XOR:  o_c = i_a ^ i_b;
      OP_ANDN: o_c = i_a & ~i_b;
      default: o_c = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/logic_operand_queue.sv
`default_nettype none
// ============================================================================
// Module      : logic_operand_queue
// Description : DEPTH-entry FIFO of {op, a, b} operand pairs feeding a
//               bitwise unit whose result is held in a registered output
//               stage with valid/ready handshake. Synchronous flush,
//               asynchronous active-low reset.
// Revision    : 1.0 - initial release
// ============================================================================
module logic_operand_queue
  import logic_operand_queue_pkg::*;
#(
  parameter int W     = c_default_w,
  parameter int DEPTH = c_default_depth
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          flush,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [W-1:0]                  in_a,
  input  logic [W-1:0]                  in_b,
  input  logic [1:0]                    in_op,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [W-1:0]                  out_c,
  output logic [count_width(DEPTH)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = count_width(DEPTH);

  localparam logic [CW-1:0] c_depth = CW'(DEPTH);
  localparam logic [PW-1:0] c_ptr_one = PW'(1);
  localparam logic [CW-1:0] c_cnt_one = CW'(1);

  // Storage is intentionally not reset; only pointers/count qualify it
  op_e          r_mem_op [DEPTH];
  logic [W-1:0] r_mem_a  [DEPTH];
  logic [W-1:0] r_mem_b  [DEPTH];

  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_out_valid;
  logic [W-1:0]  r_out_c;

  logic          w_push;
  logic          w_pop;
  logic [W-1:0]  w_result;

  // Ready depends only on occupancy, so a full queue refuses a push even
  // when a pop frees an entry in the same cycle
  assign in_ready  = (r_count < c_depth);
  assign w_push    = in_valid && in_ready && !flush;
  assign w_pop     = (r_count != '0) && !flush && (!r_out_valid || out_ready);

  assign out_valid = r_out_valid;
  assign out_c     = r_out_c;
  assign count     = r_count;

  logic32b_comb #(
    .W (W)
  ) u_logic32b_comb (
    .i_op (r_mem_op[r_rd_ptr]),
    .i_a  (r_mem_a[r_rd_ptr]),
    .i_b  (r_mem_b[r_rd_ptr]),
    .o_c  (w_result)
  );

  // Write the offered operand pair into the slot under the write pointer
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_op[r_wr_ptr] <= op_e'(in_op);
      r_mem_a[r_wr_ptr]  <= in_a;
      r_mem_b[r_wr_ptr]  <= in_b;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is 2^n)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_ptr_one;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_one;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_cnt_one;
        2'b01:   r_count <= r_count - c_cnt_one;
        default: r_count <= r_count;
      endcase
    end
  end

  // Output register: load on pop, drop when consumed, hold under backpressure
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_c     <= '0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
    end else if (w_pop) begin
      r_out_valid <= 1'b1;
      r_out_c     <= w_result;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_logic_operand_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_logic_operand_queue
// Description : Self-checking scoreboard bench for logic_operand_queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_logic_operand_queue;

  localparam int W     = 32;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_a;
  logic [W-1:0]  in_b;
  logic [1:0]    in_op;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_c;
  logic [CW-1:0] count;

  int n_chk  = 0;
  int n_pass = 0;
  int n_out  = 0;

  logic [W-1:0] exp_q[$];

  logic32b_dummy_guard u_unused_guard_placeholder_never ();

  logic_operand_queue #(.W(W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_c     (out_c),
    .count     (count)
  );

  always #5 clk = ~clk;

  // Reference behaviour of one operation, straight from the op table
  function automatic logic [W-1:0] ref_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < W; i++) begin
      case (op)
        2'b00: r[i] = a[i] & b[i];
        2'b01: r[i] = a[i] | b[i];
        2'b10: r[i] = a[i] ^ b[i];
        default: r[i] = a[i] & ~b[i];
      endcase
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Monitor: every accepted result is compared against the oldest expectation
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      n_out++;
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_result: got 0x%0h expected none", out_c);
      end else begin
        chk("result", 64'(out_c), 64'(exp_q.pop_front()));
      end
    end
  end

  // Advance one clock; records accepted pushes at the stable mid-cycle point
  task automatic cycle();
    @(negedge clk);
    if (rst_n && !flush && in_valid && in_ready)
      exp_q.push_back(ref_op(in_op, in_a, in_b));
    if (flush) exp_q.delete();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic v, input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    in_valid = v;
    in_op    = op;
    in_a     = a;
    in_b     = b;
  endtask

  task automatic drain(input string name);
    set_in(1'b0, 2'b00, '0, '0);
    out_ready = 1'b1;
    for (int i = 0; i < 20 && (exp_q.size() != 0 || out_valid); i++) cycle();
    chk(name, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    logic [W-1:0] held;
    int           base;

    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
    set_in(1'b0, 2'b00, '0, '0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_c", 64'(out_c), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single AND: two-edge latency
    set_in(1'b1, 2'b00, 32'hFFFF0000, 32'h0F0F0F0F);
    cycle();
    set_in(1'b0, 2'b00, '0, '0);
    chk("and_lat_edge1_valid", 64'(out_valid), 64'd0);
    cycle();
    chk("and_edge2_valid", 64'(out_valid), 64'd1);
    chk("and_edge2_out_c", 64'(out_c), 64'h0F0F0000);
    drain("and_drain");

    // Fill under backpressure with 5 OR ops
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_in(1'b1, 2'b01, $urandom, $urandom);
      if (i == 0) held = ref_op(2'b01, in_a, in_b);
      cycle();
    end
    set_in(1'b0, 2'b00, '0, '0);
    chk("fill_count", 64'(count), 64'd4);
    chk("fill_in_ready", 64'(in_ready), 64'd0);
    chk("fill_out_c_first", 64'(out_c), 64'(held));
    cycle();
    cycle();
    chk("fill_out_c_stable", 64'(out_c), 64'(held));
    chk("fill_valid_stable", 64'(out_valid), 64'd1);

    // Drain from full while a push is offered: the push must be refused
    base = n_out;
    set_in(1'b1, 2'b10, $urandom, $urandom);
    out_ready = 1'b1;
    cycle();
    chk("full_no_push_count", 64'(count), 64'd3);
    drain("full_drain");
    chk("full_drain_results", 64'(n_out - base), 64'd5);

    // Streaming 16 XOR/ANDN pairs, one result per cycle
    base = n_out;
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (i == 0) set_in(1'b1, 2'b11, 32'hAAAAAAAA, 32'hFFFF0000);
      else        set_in(1'b1, ($urandom_range(0, 1) != 0) ? 2'b11 : 2'b10, $urandom, $urandom);
      cycle();
      if (i == 1) chk("stream_andn_first", 64'(out_c), 64'h0000AAAA);
    end
    set_in(1'b0, 2'b00, '0, '0);
    cycle();
    cycle();
    chk("stream_results_in_window", 64'(n_out - base), 64'd16);
    chk("stream_empty", 64'(count), 64'd0);

    // Flush with count=3 and out_valid=1; same-cycle push dropped
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_in(1'b1, 2'b01, $urandom, $urandom);
      cycle();
    end
    chk("preflush_count", 64'(count), 64'd3);
    chk("preflush_valid", 64'(out_valid), 64'd1);
    set_in(1'b1, 2'b00, $urandom, $urandom);
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    set_in(1'b0, 2'b00, '0, '0);
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_valid", 64'(out_valid), 64'd0);
    cycle();
    chk("flush_push_dropped_count", 64'(count), 64'd0);
    chk("flush_push_dropped_valid", 64'(out_valid), 64'd0);

    // Asynchronous reset between edges with count=2
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, 2'b10, $urandom, $urandom);
      cycle();
    end
    set_in(1'b0, 2'b00, '0, '0);
    chk("prereset_count", 64'(count), 64'd2);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    chk("async_rst_count", 64'(count), 64'd0);
    chk("async_rst_valid", 64'(out_valid), 64'd0);
    chk("async_rst_out_c", 64'(out_c), 64'd0);
    chk("async_rst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Randomized traffic with occasional flush; occupancy tracked by model
    for (int i = 0; i < 300; i++) begin
      set_in(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), $urandom, $urandom);
      flush = ($urandom_range(0, 40) == 0);
      out_ready = flush ? 1'b0 : ($urandom_range(0, 2) != 0);
      cycle();
      flush = 1'b0;
      chk("rand_occupancy", 64'(count) + 64'(out_valid), 64'(exp_q.size()));
    end
    drain("rand_drain");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// Empty helper so the bench compiles standalone with no extra ports
module logic32b_dummy_guard;
endmodule
`default_nettype wire
